// File: rtl/multi_word_adder_sequencer.sv
// Multi-word adder: steps one 32-bit look-ahead adder across WORDS slices, carrying between cycles.
// Optional subtract mode is enabled by defining MULTI_WORD_ADDER_SUBTRACT_EN (adds the Subtract_In port).

module Look_Ahead_Carry_Generator_32_Bit (
  input  logic [31:0] A_In,
  input  logic [31:0] B_In,
  input  logic        Carry_In,
  output logic [31:0] Sum_Out,
  output logic        Carry_Out
);
  logic [31:0] gen;
  logic [31:0] prop;
  logic [31:0] bit_carry;
  logic [7:0]  grp_gen;
  logic [7:0]  grp_prop;
  logic [8:0]  grp_carry;

  assign gen  = A_In & B_In;
  assign prop = A_In ^ B_In;

  // Eight 4-bit groups; each group's internal carries are fully expanded from its carry-in.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_group
      logic [3:0] g;
      logic [3:0] p;
      logic       cin_g;
      assign g     = gen[gi*4 +: 4];
      assign p     = prop[gi*4 +: 4];
      assign cin_g = grp_carry[gi];

      assign grp_gen[gi]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
                            (p[3] & p[2] & p[1] & g[0]);
      assign grp_prop[gi] = &p;

      assign bit_carry[gi*4 + 0] = cin_g;
      assign bit_carry[gi*4 + 1] = g[0] | (p[0] & cin_g);
      assign bit_carry[gi*4 + 2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_g);
      assign bit_carry[gi*4 + 3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
                                   (p[2] & p[1] & p[0] & cin_g);
    end
  endgenerate

  // Each group carry is derived from Carry_In and the group terms alone, not from a neighbour's carry.
  always_comb begin
    logic chain;
    grp_carry[0] = Carry_In;
    for (int j = 0; j < 8; j++) begin
      chain = Carry_In;
      for (int k = 0; k <= j; k++) begin
        chain = grp_gen[k] | (grp_prop[k] & chain);
      end
      grp_carry[j+1] = chain;
    end
  end

  assign Sum_Out   = prop ^ bit_carry;
  assign Carry_Out = grp_carry[8];
endmodule

module multi_word_adder_sequencer #(
  parameter int WORDS = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start_In,
  input  logic [WORDS*32-1:0] Data_A_In,
  input  logic [WORDS*32-1:0] Data_B_In,
  input  logic               Carry_In,
`ifdef MULTI_WORD_ADDER_SUBTRACT_EN
  input  logic               Subtract_In,
`endif
  output logic               Busy_Out,
  output logic               Done_Out,
  output logic [WORDS*32-1:0] Sum_Out,
  output logic               Carry_Out,
  output logic               Overflow_Out
);
  localparam int W     = WORDS * 32;
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [W-1:0]     b_latch;
  logic             cin_latch;
  logic [31:0]      slice_a;
  logic [31:0]      slice_b;
  logic [31:0]      slice_sum;
  logic             slice_cout;

`ifdef MULTI_WORD_ADDER_SUBTRACT_EN
  // Subtraction is A + ~B + 1, so the inversion and forced carry happen once, at latch time.
  assign b_latch   = Subtract_In ? ~Data_B_In : Data_B_In;
  assign cin_latch = Subtract_In ? 1'b1 : Carry_In;
`else
  assign b_latch   = Data_B_In;
  assign cin_latch = Carry_In;
`endif

  assign slice_a = a_q[{index_q, 5'd0} +: 32];
  assign slice_b = b_q[{index_q, 5'd0} +: 32];

  Look_Ahead_Carry_Generator_32_Bit u_adder (
    .A_In      (slice_a),
    .B_In      (slice_b),
    .Carry_In  (carry_q),
    .Sum_Out   (slice_sum),
    .Carry_Out (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start_In) begin
          a_d     = Data_A_In;
          b_d     = b_latch;
          carry_d = cin_latch;
          index_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d[{index_q, 5'd0} +: 32] = slice_sum;
        carry_d = slice_cout;
        index_d = index_q + 1'b1;
        if (index_q == IDX_W'(WORDS - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Result, carry and overflow all commit on the same edge as the Done pulse.
        sum_d   = acc_q;
        cout_d  = carry_q;
        ovf_d   = (a_q[W-1] == b_q[W-1]) && (acc_q[W-1] != a_q[W-1]);
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign Busy_Out     = (state_q != ST_IDLE);
  assign Done_Out     = done_q;
  assign Sum_Out      = sum_q;
  assign Carry_Out    = cout_q;
  assign Overflow_Out = ovf_q;
endmodule

// File: tb/tb_multi_word_adder_sequencer.sv
// Randomised and directed checks of multi_word_adder_sequencer against a full-width arithmetic model.
module tb_multi_word_adder_sequencer;
  localparam int WORDS = 4;
  localparam int W     = WORDS * 32;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Start_In;
  logic [W-1:0] Data_A_In;
  logic [W-1:0] Data_B_In;
  logic         Carry_In;
`ifdef MULTI_WORD_ADDER_SUBTRACT_EN
  logic         Subtract_In;
`endif
  logic         Busy_Out;
  logic         Done_Out;
  logic [W-1:0] Sum_Out;
  logic         Carry_Out;
  logic         Overflow_Out;

  int vectors     = 0;
  int miscompares = 0;

  multi_word_adder_sequencer #(.WORDS(WORDS)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Start_In     (Start_In),
    .Data_A_In    (Data_A_In),
    .Data_B_In    (Data_B_In),
    .Carry_In     (Carry_In),
`ifdef MULTI_WORD_ADDER_SUBTRACT_EN
    .Subtract_In  (Subtract_In),
`endif
    .Busy_Out     (Busy_Out),
    .Done_Out     (Done_Out),
    .Sum_Out      (Sum_Out),
    .Carry_Out    (Carry_Out),
    .Overflow_Out (Overflow_Out)
  );

  always #5 Clock = ~Clock;

  // Returns {overflow, carry_out, sum} for the whole-width operation.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bx;
    logic         c;
    logic [W:0]   full;
    logic         ovf;
    bx   = sub ? ~b : b;
    c    = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, c};
    ovf  = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    Data_A_In = a;
    Data_B_In = b;
    Carry_In  = cin;
`ifdef MULTI_WORD_ADDER_SUBTRACT_EN
    Subtract_In = sub;
`endif
  endtask

  // Waits for Done_Out, checking the previous Sum_Out is held meanwhile; returns edges waited.
  task automatic wait_done(input logic [W-1:0] held, input string name, output int cyc);
    cyc = 0;
    while (Done_Out !== 1'b1 && cyc < 20) begin
      vectors++;
      if (Sum_Out !== held) begin
        miscompares++;
        $display("FAIL %s sum_held: got %h want %h", name, Sum_Out, held);
      end
      step();
      cyc++;
    end
  endtask

  task automatic check_result(input string name, input logic [W+1:0] exp, input int cyc);
    vectors++;
    if (cyc !== WORDS + 1) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, WORDS + 1);
    end
    vectors++;
    if (Sum_Out !== exp[W-1:0]) begin
      miscompares++;
      $display("FAIL %s sum: got %h want %h", name, Sum_Out, exp[W-1:0]);
    end
    vectors++;
    if (Carry_Out !== exp[W]) begin
      miscompares++;
      $display("FAIL %s carry: got %b want %b", name, Carry_Out, exp[W]);
    end
    vectors++;
    if (Overflow_Out !== exp[W+1]) begin
      miscompares++;
      $display("FAIL %s overflow: got %b want %b", name, Overflow_Out, exp[W+1]);
    end
    vectors++;
    if (Busy_Out !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_in_done: got %b want 0", name, Busy_Out);
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input string name);
    logic [W+1:0] exp;
    logic [W-1:0] held;
    int           cyc;
    exp  = model(a, b, cin, sub);
    held = Sum_Out;
    drive_op(a, b, cin, sub);
    Start_In = 1'b1;
    step();
    Start_In = 1'b0;
    vectors++;
    if (Busy_Out !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_after_start: got %b want 1", name, Busy_Out);
    end
    wait_done(held, name, cyc);
    check_result(name, exp, cyc);
    $display("op %s: a=%h b=%h cin=%b sub=%b sum=%h c=%b v=%b", name, a, b, cin, sub,
             Sum_Out, Carry_Out, Overflow_Out);
    step();
    vectors++;
    if (Done_Out !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_pulse_width: got %b want 0", name, Done_Out);
    end
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if ({Busy_Out, Done_Out, Sum_Out, Carry_Out, Overflow_Out} !== '0) begin
      miscompares++;
      $display("FAIL %s outputs_zero: busy=%b done=%b sum=%h c=%b v=%b want all 0", name,
               Busy_Out, Done_Out, Sum_Out, Carry_Out, Overflow_Out);
    end
  endtask

  task automatic test_reset();
    Reset    = 1'b1;
    Start_In = 1'b0;
    drive_op('0, '0, 1'b0, 1'b0);
    repeat (3) step();
    check_all_zero("reset");
    Reset = 1'b0;
    step();
    check_all_zero("reset_release");
    $display("test_reset done");
  endtask

  task automatic test_directed();
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = '1;
    b = 1;
    do_op(a, b, 1'b0, 1'b0, "all_ones_plus_one");
    a = {{(W-32){1'b0}}, 32'hFFFF_FFFF};
    do_op(a, b, 1'b0, 1'b0, "inter_slice_carry");
    a = {1'b0, {(W-1){1'b1}}};
    b = '0;
    do_op(a, b, 1'b1, 1'b0, "signed_overflow");
  endtask

  task automatic test_random();
    logic sub;
    for (int i = 0; i < 12; i++) begin
      sub = 1'b0;
`ifdef MULTI_WORD_ADDER_SUBTRACT_EN
      sub = 1'($urandom_range(0, 1));
`endif
      do_op(rand_wide(), rand_wide(), 1'($urandom_range(0, 1)), sub, "random");
    end
  endtask

  task automatic test_start_while_busy();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W+1:0] exp;
    logic [W-1:0] held;
    int           cyc;
    int           extra;
    a    = rand_wide();
    b    = rand_wide();
    exp  = model(a, b, 1'b0, 1'b0);
    held = Sum_Out;
    drive_op(a, b, 1'b0, 1'b0);
    Start_In = 1'b1;
    step();
    cyc = 0;
    while (Done_Out !== 1'b1 && cyc < 20) begin
      if (cyc == 1 || cyc == 3) begin
        Start_In  = 1'b1;
        Data_A_In = rand_wide();
        Data_B_In = rand_wide();
        Carry_In  = 1'b1;
      end else begin
        Start_In = 1'b0;
      end
      vectors++;
      if (Sum_Out !== held) begin
        miscompares++;
        $display("FAIL busy_start sum_held: got %h want %h", Sum_Out, held);
      end
      step();
      cyc++;
    end
    Start_In = 1'b0;
    check_result("busy_start", exp, cyc);
    extra = 0;
    for (int i = 0; i < 2 * WORDS + 4; i++) begin
      step();
      if (Done_Out === 1'b1) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("FAIL busy_start extra_done: got %0d want 0", extra);
    end
    $display("op busy_start: sum=%h extra_done=%0d", Sum_Out, extra);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    logic [W+1:0] exp1, exp2;
    int           cyc;
    a1 = rand_wide(); b1 = rand_wide();
    a2 = rand_wide(); b2 = rand_wide();
    exp1 = model(a1, b1, 1'b1, 1'b0);
    exp2 = model(a2, b2, 1'b0, 1'b0);
    drive_op(a1, b1, 1'b1, 1'b0);
    Start_In = 1'b1;
    step();
    drive_op(a2, b2, 1'b0, 1'b0);
    wait_done(Sum_Out, "b2b_first", cyc);
    check_result("b2b_first", exp1, cyc);
    step();
    Start_In = 1'b0;
    vectors++;
    if (Busy_Out !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b second_accept: busy got %b want 1", Busy_Out);
    end
    wait_done(exp1[W-1:0], "b2b_second", cyc);
    check_result("b2b_second", exp2, cyc);
    $display("op back_to_back: sum1=%h sum2=%h", exp1[W-1:0], Sum_Out);
    step();
  endtask

  task automatic test_reset_mid_run();
    int dones;
    do_op(3, 4, 1'b0, 1'b0, "pre_reset");
    drive_op(rand_wide(), rand_wide(), 1'b1, 1'b0);
    Start_In = 1'b1;
    step();
    Start_In = 1'b0;
    step();
    step();
    Reset = 1'b1;
    #1;
    check_all_zero("reset_mid_run");
    step();
    Reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 2 * WORDS + 4; i++) begin
      step();
      if (Done_Out === 1'b1) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_run done_after_reset: got %0d want 0", dones);
    end
    check_all_zero("reset_mid_run_idle");
    do_op(rand_wide(), rand_wide(), 1'b0, 1'b0, "after_reset");
  endtask

`ifdef MULTI_WORD_ADDER_SUBTRACT_EN
  task automatic test_subtract();
    do_op(5, 7, 1'b0, 1'b1, "subtract_5_minus_7");
    vectors++;
    if (Sum_Out !== {{(W-4){1'b1}}, 4'hE}) begin
      miscompares++;
      $display("FAIL subtract literal: got %h", Sum_Out);
    end
    do_op(9, 4, 1'b0, 1'b1, "subtract_9_minus_4");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
`ifdef MULTI_WORD_ADDER_SUBTRACT_EN
    test_subtract();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
